// File: rtl/hex_display_ctrl.sv
// Multi-page 7-segment hex display: captures a value, pages through its nibbles,
// with optional leading-zero blanking and whole-display blinking.
module hex_display_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000,
  localparam int PAGES     = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
  localparam int PAGE_W    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    nRST,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    load,
  input  logic                    freeze,
  input  logic                    page_next,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic [NUM_DIGITS*7-1:0] seg,
  output logic [PAGE_W-1:0]       page,
  output logic                    captured
);

  localparam int NIBS  = DATA_W / 4;
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [DATA_W-1:0]       data_q, data_d;
  logic                    captured_q, captured_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  logic [CNT_W-1:0]        blinkCnt_q, blinkCnt_d;
  logic                    blinkPhase_q, blinkPhase_d;
  logic [NIBS:0]           zeroFrom;
  logic [NUM_DIGITS*7-1:0] segAll;
  logic [6:0]              digit;
  int                      nibIdx;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0: hexToSeg = 7'b1000000;
      4'h1: hexToSeg = 7'b1111001;
      4'h2: hexToSeg = 7'b0100100;
      4'h3: hexToSeg = 7'b0110000;
      4'h4: hexToSeg = 7'b0011001;
      4'h5: hexToSeg = 7'b0010010;
      4'h6: hexToSeg = 7'b0000010;
      4'h7: hexToSeg = 7'b1111000;
      4'h8: hexToSeg = 7'b0000000;
      4'h9: hexToSeg = 7'b0010000;
      4'hA: hexToSeg = 7'b0001000;
      4'hB: hexToSeg = 7'b0000011;
      4'hC: hexToSeg = 7'b0100111;
      4'hD: hexToSeg = 7'b0100001;
      4'hE: hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    data_d     = data_q;
    captured_d = captured_q;
    if (load && !freeze) begin
      data_d     = data_in;
      captured_d = 1'b1;
    end

    page_d = page_q;
    if (page_next) begin
      page_d = (page_q == PAGE_W'(PAGES-1)) ? '0 : page_q + 1'b1;
    end

    // Counter and phase sit at zero while disabled so blinking starts visible.
    blinkCnt_d   = '0;
    blinkPhase_d = 1'b0;
    if (blink_en) begin
      blinkPhase_d = blinkPhase_q;
      if (blinkCnt_q == CNT_W'(BLINK_DIV-1)) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nRST) begin
    if (!nRST) begin
      data_q       <= '0;
      captured_q   <= 1'b0;
      page_q       <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      captured_q   <= captured_d;
      page_q       <= page_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // zeroFrom[n] is set when nibbles n..NIBS-1 are all zero.
  always_comb begin
    zeroFrom       = '0;
    zeroFrom[NIBS] = 1'b1;
    for (int n = NIBS-1; n >= 0; n--) begin
      zeroFrom[n] = zeroFrom[n+1] && (data_q[4*n +: 4] == 4'h0);
    end
  end

  always_comb begin
    segAll = '1;
    nibIdx = 0;
    digit  = 7'h7F;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibIdx = int'(page_q) * NUM_DIGITS + k;
      if ((blink_en && blinkPhase_q) || !captured_q || nibIdx >= NIBS) begin
        digit = 7'h7F;
      end else if (lz_blank && nibIdx != 0 && zeroFrom[nibIdx]) begin
        digit = 7'h7F;
      end else begin
        digit = hexToSeg(data_q[4*nibIdx +: 4]);
      end
      segAll[7*k +: 7] = digit;
    end
  end

  assign seg      = segAll;
  assign page     = page_q;
  assign captured = captured_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a 40-bit value (two pages) and a
// short blink period so paging, blanking and blinking are all reachable.
module tb_hex_display_ctrl;

  localparam int DATA_W     = 40;
  localparam int NUM_DIGITS = 8;
  localparam int BLINK_DIV  = 4;
  localparam int PAGE_W     = 1;

  logic                    CLOCK_50 = 1'b0;
  logic                    nRST;
  logic [DATA_W-1:0]       data_in;
  logic                    load, freeze, page_next, lz_blank, blink_en;
  logic [NUM_DIGITS*7-1:0] seg;
  logic [PAGE_W-1:0]       page;
  logic                    captured;

  int checks   = 0;
  int failures = 0;

  hex_display_ctrl #(
    .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .CLOCK_50(CLOCK_50), .nRST(nRST), .data_in(data_in), .load(load),
    .freeze(freeze), .page_next(page_next), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg), .page(page), .captured(captured)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Display image from a string written digit 7 first; ' ' is a blank digit.
  function automatic logic [55:0] expSeg(input string s);
    logic [6:0] d;
    expSeg = '1;
    for (int i = 0; i < 8; i++) begin
      case (s[i])
        "0": d = 7'b1000000;
        "1": d = 7'b1111001;
        "2": d = 7'b0100100;
        "3": d = 7'b0110000;
        "4": d = 7'b0011001;
        "5": d = 7'b0010010;
        "6": d = 7'b0000010;
        "7": d = 7'b1111000;
        "8": d = 7'b0000000;
        "9": d = 7'b0010000;
        "A": d = 7'b0001000;
        "b": d = 7'b0000011;
        "c": d = 7'b0100111;
        "d": d = 7'b0100001;
        "E": d = 7'b0000110;
        "F": d = 7'b0001110;
        default: d = 7'b1111111;
      endcase
      expSeg[7*(7-i) +: 7] = d;
    end
  endfunction

  task automatic applyStimulus(input logic ld, input logic frz, input logic pn,
                               input logic lz, input logic bl, input logic [DATA_W-1:0] d);
    load      = ld;
    freeze    = frz;
    page_next = pn;
    lz_blank  = lz;
    blink_en  = bl;
    data_in   = d;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, '0);
    #2;
    // Reset state, sampled before any clock edge
    checkOutput("rst_seg", 64'(seg), 64'(expSeg("        ")));
    checkOutput("rst_page", 64'(page), 64'd0);
    checkOutput("rst_captured", 64'(captured), 64'd0);
    tick();
    tick();
    #3;
    nRST = 1'b1;
    tick();
    checkOutput("post_rst_seg", 64'(seg), 64'(expSeg("        ")));
    checkOutput("post_rst_captured", 64'(captured), 64'd0);

    // Basic capture
    applyStimulus(1, 0, 0, 0, 0, 40'h001234ABCD);
    tick();
    checkOutput("cap_seg", 64'(seg), 64'(expSeg("1234Abcd")));
    checkOutput("cap_captured", 64'(captured), 64'd1);

    // Freeze blocks capture, release captures next edge
    applyStimulus(1, 1, 0, 0, 0, 40'hFFFFFFFFFF);
    tick();
    checkOutput("freeze_seg", 64'(seg), 64'(expSeg("1234Abcd")));
    applyStimulus(1, 0, 0, 0, 0, 40'hFFFFFFFFFF);
    tick();
    checkOutput("unfreeze_seg", 64'(seg), 64'(expSeg("FFFFFFFF")));
    applyStimulus(0, 0, 0, 0, 0, 40'h0000000000);
    tick();
    checkOutput("hold_seg", 64'(seg), 64'(expSeg("FFFFFFFF")));

    // Leading-zero blanking
    applyStimulus(1, 0, 0, 1, 0, 40'h00000000A0);
    tick();
    checkOutput("lz_a0", 64'(seg), 64'(expSeg("      A0")));
    applyStimulus(1, 0, 0, 1, 0, 40'h0000000000);
    tick();
    checkOutput("lz_zero", 64'(seg), 64'(expSeg("       0")));
    applyStimulus(0, 0, 0, 0, 0, 40'h0000000000);
    tick();
    checkOutput("nolz_zero", 64'(seg), 64'(expSeg("00000000")));

    // Paging across the 40-bit value
    applyStimulus(1, 0, 0, 0, 0, 40'hC0FFEE1234);
    tick();
    checkOutput("pg0_seg", 64'(seg), 64'(expSeg("FFEE1234")));
    checkOutput("pg0_page", 64'(page), 64'd0);
    applyStimulus(0, 0, 1, 0, 0, 40'h0);
    tick();
    checkOutput("pg1_seg", 64'(seg), 64'(expSeg("      c0")));
    checkOutput("pg1_page", 64'(page), 64'd1);
    tick();
    checkOutput("pg_wrap_page", 64'(page), 64'd0);
    checkOutput("pg_wrap_seg", 64'(seg), 64'(expSeg("FFEE1234")));

    // Capture and page advance on the same edge
    applyStimulus(1, 0, 1, 0, 0, 40'h0000000005);
    tick();
    checkOutput("both_page", 64'(page), 64'd1);
    checkOutput("both_seg", 64'(seg), 64'(expSeg("      00")));
    applyStimulus(0, 0, 0, 1, 0, 40'h0);
    tick();
    checkOutput("lz_pg1_seg", 64'(seg), 64'(expSeg("        ")));
    applyStimulus(1, 0, 1, 0, 0, 40'h0012345678);
    tick();
    checkOutput("back_pg0_seg", 64'(seg), 64'(expSeg("12345678")));

    // Blinking: 4 visible clocks, 4 blank clocks
    applyStimulus(0, 0, 0, 0, 1, 40'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("blink_%0d", i), 64'(seg),
                  64'((i >= 4 && i <= 7) ? expSeg("        ") : expSeg("12345678")));
    end
    tick();
    tick();
    tick();
    tick();
    checkOutput("blink_12", 64'(seg), 64'(expSeg("        ")));
    applyStimulus(0, 0, 0, 0, 0, 40'h0);
    tick();
    checkOutput("blink_off", 64'(seg), 64'(expSeg("12345678")));

    // Asynchronous reset mid-blank on page 1
    applyStimulus(0, 0, 1, 0, 0, 40'h0);
    tick();
    checkOutput("pre_rst_page", 64'(page), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 40'h0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("pre_rst_blank", 64'(seg), 64'(expSeg("        ")));
    #3;
    nRST = 1'b0;
    #1;
    checkOutput("async_page", 64'(page), 64'd0);
    checkOutput("async_captured", 64'(captured), 64'd0);
    checkOutput("async_seg", 64'(seg), 64'(expSeg("        ")));
    applyStimulus(0, 0, 0, 0, 0, 40'h0);
    #2;
    nRST = 1'b1;
    tick();
    checkOutput("rerelease_seg", 64'(seg), 64'(expSeg("        ")));
    applyStimulus(1, 0, 0, 0, 0, 40'h001234ABCD);
    tick();
    checkOutput("recap_seg", 64'(seg), 64'(expSeg("1234Abcd")));
    checkOutput("recap_captured", 64'(captured), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the captured value width in bits; it must be a multiple of 4 and at least 4.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of 7-segment digits driven.
REQ-003 The block SHALL have parameter BLINK_DIV, default 25_000_000, giving the number of clocks per blink half-period; it must be at least 2.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port data_in, input, DATA_W bits: the value offered for capture.
REQ-007 The block SHALL have port load, input, 1 bit: capture strobe.
REQ-008 The block SHALL have port freeze, input, 1 bit: level input; when high it blocks capture.
REQ-009 The block SHALL have port page_next, input, 1 bit: single-cycle pulse that advances the displayed page.
REQ-010 The block SHALL have port lz_blank, input, 1 bit: level input; when high it enables leading-zero blanking.
REQ-011 The block SHALL have port blink_en, input, 1 bit: level input; when high it enables display blinking.
REQ-012 The block SHALL have port seg, output, NUM_DIGITS*7 bits: digit k occupies bits [7k+6:7k], segment order gfedcba, active-low.
REQ-013 The block SHALL have port page, output, max(1,$clog2(PAGES)) bits: index of the page currently displayed.
REQ-014 The block SHALL have port captured, output, 1 bit: high once any value has been captured since reset.

Function
REQ-015 PAGES SHALL equal ceil(DATA_W / (4*NUM_DIGITS)); nibble index n of the captured value is held at bits [4n+3:4n].
REQ-016 The captured value register SHALL load data_in on a rising edge where load=1 and freeze=0; under any other condition it holds.
REQ-017 The captured output SHALL go to 1 on the first capture edge and stay 1 until reset.
REQ-018 seg SHALL be decoded combinationally from registered state only, so a capture is visible on seg immediately after its capture edge (1-edge latency) and data_in never reaches seg directly.
REQ-019 Digit k SHALL display nibble index page*NUM_DIGITS+k; a nibble index at or beyond DATA_W/4 SHALL display blank (7'b1111111).
REQ-020 The nibble decode SHALL be fixed: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
REQ-021 The page register SHALL increment on a rising edge where page_next=1; from PAGES-1 it SHALL wrap to 0; when PAGES=1 it SHALL stay at 0.
REQ-022 Capture and page advance on the same edge SHALL both take effect, with no priority between them.
REQ-023 When lz_blank=1, the digit for nibble n SHALL show blank if every nibble n..DATA_W/4-1 of the captured value is 0, except nibble 0, which is never blanked.
REQ-024 When lz_blank=0, no leading-zero blanking SHALL occur.
REQ-025 The blink counter SHALL count 0..BLINK_DIV-1 and wrap; on each wrap it SHALL toggle blink_phase.
REQ-026 While blink_en=0, the blink counter and blink_phase SHALL be held at 0, so blinking always starts in the visible phase.
REQ-027 When blink_en=1 and blink_phase=1, all digits SHALL show blank; blinking overrides decode and leading-zero blanking but does not alter the captured value or page.
REQ-028 Blank priority SHALL be: blink, then out-of-range nibble, then leading zero, then decode.

Reset
REQ-029 While nRST=0, the captured value SHALL be 0, page SHALL be 0, captured SHALL be 0, and the blink counter and blink_phase SHALL be 0.
REQ-030 While nRST=0 and the cycle after release, seg SHALL show every digit blank (7'b1111111), since captured=0 forces blank until the first capture.
REQ-031 Reset asserted mid-blink or mid-page SHALL return the block to the REQ-029 state immediately, without waiting for a clock edge.
REQ-032 After release, the first capture edge SHALL display normally.

Verification
REQ-033 With defaults, reset, then load=1 with data_in=32'h1234ABCD -> seg digits 7..0 = 1,2,3,4,A,b,c,d; captured=1 one edge later.
REQ-034 freeze=1 with load=1 and data_in=32'hFFFFFFFF -> display unchanged at 1234ABCD; then freeze=0 -> next edge captures FFFFFFFF.
REQ-035 lz_blank=1 with captured 32'h000000A0 -> digits 7..2 blank, digit 1 = A, digit 0 = 0; captured 0 -> only digit 0 = 0.
REQ-036 DATA_W=40, NUM_DIGITS=8, value 40'hC0FFEE1234 -> page 0 shows FFEE1234; one page_next -> page 1 shows digit 0=0, digit 1=C, digits 7..2 blank; second page_next -> page wraps to 0.
REQ-037 BLINK_DIV=4, blink_en=1 -> seg visible 4 clocks, blank 4 clocks, repeating; blink_en=0 mid-blank -> visible on the next edge.
REQ-038 Assert nRST asynchronously mid-blank on page 1 -> page=0, captured=0, all digits blank, with no clock edge required.
